// File: rtl/mult_control.sv
// Sequencing controller for the add-shift multiplier datapath: turns the Execute and
// ClearXA_LoadB levels into per-cycle clear/load/add/shift strobes, one multiply per press.
module mult_control #(
    parameter int unsigned WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Execute,
    input  logic ClearXA_LoadB,
    input  logic M,
    output logic Clr_XA,
    output logic Ld_B,
    output logic Ld_XA,
    output logic Sub,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAdd,
        StShift,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_iter;

    assign last_iter = (cnt_q == CntLast);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        Clr_XA   = 1'b0;
        Ld_B     = 1'b0;
        Ld_XA    = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Execute) begin
                    state_d = StClear;
                end else if (ClearXA_LoadB && Reset_n) begin
                    // Mealy load strobes must stay low while reset is held
                    Clr_XA = 1'b1;
                    Ld_B   = 1'b1;
                end
            end
            StClear: begin
                Clr_XA  = 1'b1;
                Busy    = 1'b1;
                cnt_d   = '0;
                state_d = StAdd;
            end
            StAdd: begin
                Busy    = 1'b1;
                Ld_XA   = M;
                // Last multiplier bit carries negative weight in two's complement
                Sub     = M & last_iter;
                state_d = StShift;
            end
            StShift: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (last_iter) begin
                    state_d = StHold;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    state_d = StAdd;
                end
            end
            StHold: begin
                Done = 1'b1;
                if (!Execute) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing controller for the 8-bit add-shift multiplier datapath (X bit, registers A and B, 9-bit adder/subtractor). It converts the synchronized Execute and ClearXA_LoadB pushbutton levels into per-cycle strobes: clear X:A, load B, conditional add or subtract into X:A, and arithmetic shift of X:A:B. Each Execute press runs exactly one multiply of WIDTH iterations, then holds until the button is released. It replaces the ad-hoc control wiring at the top level and is the only source of datapath strobes.

## Interface
- WIDTH, 8, number of multiplier bits; iteration count (>=2)
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Execute  in  1  synchronized active-high Execute level
- ClearXA_LoadB  in  1  synchronized active-high clear/load level
- M  in  1  current B[0] from the datapath
- Clr_XA  out  1  clear X and A this cycle
- Ld_B  out  1  load B from switch data this cycle
- Ld_XA  out  1  load adder result into X:A this cycle
- Sub  out  1  adder in subtract mode (valid whenever Ld_XA=1)
- Shift_En  out  1  shift X:A:B right one bit this cycle
- Busy  out  1  multiply in progress
- Done  out  1  multiply complete, waiting for Execute release

## Operation
- States: IDLE, CLEAR, ADD, SHIFT, HOLD. Iteration counter cnt, $clog2(WIDTH) bits.
- IDLE: Busy=0, Done=0. If Execute=1 -> CLEAR (Execute has priority; no Ld_B that cycle). Else if ClearXA_LoadB=1: Clr_XA=1 and Ld_B=1 combinationally, every cycle the level is high; stay IDLE.
- CLEAR: Clr_XA=1, Busy=1, cnt<=0 -> ADD.
- ADD: Busy=1. Ld_XA=M (Mealy). Sub=1 iff cnt==WIDTH-1, else 0. -> SHIFT.
- SHIFT: Busy=1, Shift_En=1. If cnt==WIDTH-1 -> HOLD, else cnt<=cnt+1 -> ADD.
- HOLD: Done=1, Busy=0, no strobes. Execute=0 -> IDLE; Execute=1 -> stay. Holding Execute never starts a second multiply.
- Execute and ClearXA_LoadB ignored in CLEAR/ADD/SHIFT; ClearXA_LoadB ignored in HOLD.
- At most one of {Clr_XA/Ld_B, Ld_XA, Shift_En} groups is active in any cycle. Sub=0 whenever Ld_XA=0.
- Counter wraps never: cnt only increments in SHIFT with cnt<WIDTH-1.

## Timing
- Reset (Reset_n=0): state=IDLE, cnt=0 immediately (asynchronous); all outputs 0 while Reset_n=0, including Mealy outputs. Release is synchronous to next Clk edge.
- Reset mid-multiply: strobes drop at once; datapath contents left as-is; next Execute restarts from CLEAR.
- Latency: Execute high sampled in IDLE at edge 0 -> CLEAR cycle 1 -> ADD/SHIFT pairs cycles 2..2*WIDTH+1 -> Done=1 from cycle 2*WIDTH+2 (cycle 18 for WIDTH=8).
- Ld_XA follows M combinationally during ADD; M must be stable before the edge (B only changes on Shift_En/Ld_B edges, so it is).
- Busy and Done are Moore outputs, glitch-free.

## Test plan
- Reset: Reset_n=0 with Execute=1, ClearXA_LoadB=1 -> all outputs 0, state IDLE; release with inputs 0 -> stays IDLE.
- Load: IDLE, ClearXA_LoadB high 3 cycles -> Clr_XA=Ld_B=1 exactly those 3 cycles, Busy=0.
- Full run, M=1 constant, WIDTH=8: Execute held 40 cycles -> 1 Clr_XA, 8 Ld_XA pulses, Sub=1 only on the 8th, 8 Shift_En pulses alternating with Ld_XA, Done=1 from cycle 18 until Execute drops, no second run.
- M pattern 1,0,1,0,0,0,0,0 (bench model of B=0x05) -> Ld_XA only in ADD cycles of iterations 0 and 2, Sub never asserted with Ld_XA; end-to-end with datapath S=0x03 gives A:B=0x000F; S=0xFD (-3), B=0x05 gives 0xFFF1.
- Negative multiplier: B=0xFF, S=0x02 -> last iteration subtracts, A:B=0xFFFE.
- Reset_n pulsed low in 6th cycle of run -> outputs 0 immediately; Execute reapplied -> full 8-iteration run from CLEAR.
